if_id_fetch_stage: RTL and testbench
====================================

// Module: if_id_fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register; directly upstream of decode and the hazard detector.
//  Holds the PC and issues instruction-memory requests. Honours the hazard detector's PC and
//  IF/ID write enables, and squashes on branch/jump redirect from execute.
//  A 1-entry skid buffer keeps an instruction that returns during a stall, so it is not re-fetched.
// PARAMETERS
//  PC_W      16       PC and address width
//  INSTR_W   16       instruction width
//  RESET_PC  16'h0000 PC value loaded at reset
//  NOP_INSTR 16'h0800 bubble encoding (opcode 00001)
//  HALT_OPC  5'b00000 opcode (bits [15:11]) that stops fetch
// PORTS
//  clk                 in   1        clock
//  rst_n               in   1        synchronous, active-low reset
//  pc_write_en_in      in   1        from hazard detector; 0 = hold PC
//  if_id_write_en_in   in   1        from hazard detector; 0 = hold IF/ID
//  redirect_valid_in   in   1        taken branch/jump resolved in EX
//  redirect_pc_in      in   PC_W     redirect target
//  imem_req_out        out  1        instruction read request
//  imem_addr_out       out  PC_W     = PC register
//  imem_ready_in       in   1        data valid this cycle (same-cycle response allowed)
//  imem_data_in        in   INSTR_W  instruction data
//  if_id_instr_out     out  INSTR_W  registered instruction to decode
//  if_id_pc_plus2_out  out  PC_W     registered PC+2 of that instruction
//  if_id_valid_out     out  1        0 = bubble
//  halted_out          out  1        HALT fetched; fetch frozen
// BEHAVIOUR
//  Reset: state FETCH, PC=RESET_PC, buf_valid=0. Outputs: instr=NOP_INSTR, pc_plus2=0, valid=0,
//   halted=0. imem_req_out=0 while rst_n=0.
//  States: FETCH (request issued), HOLD (skid buffer full, no request), HALTED (no request).
//  imem_req_out = (state==FETCH). captured = req & imem_ready_in. avail = captured | buf_valid.
//  Priority per cycle (highest first):
//   1 redirect_valid_in: PC<=redirect_pc_in; IF/ID<=NOP, valid=0. buf_valid<=0.
//     Any captured data is dropped. state<=FETCH, halted<=0 (wrong-path HALT squashed).
//     Enables are ignored.
//   2 if_id_write_en_in=1 and avail: IF/ID<=(buf_valid ? buf : imem_data_in). valid=1.
//     pc_plus2=PC+2. buf_valid<=0.
//     PC<=PC+2 iff pc_write_en_in, else PC holds.
//     If loaded instr[15:11]==HALT_OPC: state<=HALTED, halted<=1; else state<=FETCH.
//   3 if_id_write_en_in=1, not avail (memory wait or HALTED): IF/ID<=NOP, valid=0; PC holds.
//   4 if_id_write_en_in=0: IF/ID holds all fields. If captured: buf<=imem_data_in, buf_valid<=1,
//     state<=HOLD. PC holds (still addresses the buffered instr).
//  Latency: instruction visible on if_id_* the cycle after the ready cycle, if unstalled.
//  PC arithmetic: modulo 2^PC_W; FFFE+2 -> 0000, no flag.
//  Simultaneous redirect + stall: redirect wins. Redirect + HALT capture: HALT discarded.
//  HOLD with stall: no request, buffer holds. HALTED: PC frozen; only reset or redirect exits.
//  Reset mid-stall or mid-wait: all state to reset values next edge; late response ignored.
// STRUCTURE
//  Shared pkg: PC_W/INSTR_W, NOP_INSTR, HALT_OPC, fetch state encoding (FETCH/HOLD/HALTED).
//  Sub-module: fetch_skid_buffer (1-entry data+valid, load/clear).
//  PC register and IF/ID register stay inline.
// TESTING
//  1 Reset, imem always ready, enables=1
//    -> addr 0000,0002,0004; IF/ID valid 1 from cycle 2, pc_plus2 0002,0004.
//  2 Stall 2 cycles while ready returns instr at PC 0004
//    -> IF/ID holds, req drops (HOLD). On release: instr from buffer, PC->0006, no refetch of 0004.
//  3 imem_ready low 3 cycles -> 3 bubbles (valid 0, instr 0800), PC stays, req stays 1.
//  4 Redirect to 0040 during stall with buffer full
//    -> next cycle PC=0040, valid 0, buffer cleared, req=1.
//  5 Fetch HALT (0x0000) -> halted 1, req 0, PC frozen.
//    Redirect to 0010 -> halted 0, fetch resumes at 0010.
//  6 PC=FFFE, ready -> next PC 0000, pc_plus2 0000. rst_n low mid-wait -> all outputs reset next edge.

Source files
------------

// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants and fetch FSM encoding for the IF stage and its IF/ID register.
package if_id_fetch_stage_pkg;

  localparam int unsigned FETCH_PC_W      = 16;
  localparam int unsigned FETCH_INSTR_W   = 16;
  localparam logic [15:0] FETCH_RESET_PC  = 16'h0000;
  localparam logic [15:0] FETCH_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  FETCH_HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_HOLD,
    ST_HALTED
  } fetch_state_e;

endpackage

// File: rtl/if_id_fetch_stage_skid_buffer.sv
// One-entry holding register for an instruction that returns while IF/ID is stalled.
module fetch_skid_buffer #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register, instruction-memory request, skid buffer and IF/ID register.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter int unsigned        PC_W      = FETCH_PC_W,
  parameter int unsigned        INSTR_W   = FETCH_INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC  = FETCH_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = FETCH_NOP_INSTR,
  parameter logic [4:0]         HALT_OPC  = FETCH_HALT_OPC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write_en_in,
  input  logic               if_id_write_en_in,
  input  logic               redirect_valid_in,
  input  logic [PC_W-1:0]    redirect_pc_in,
  output logic               imem_req_out,
  output logic [PC_W-1:0]    imem_addr_out,
  input  logic               imem_ready_in,
  input  logic [INSTR_W-1:0] imem_data_in,
  output logic [INSTR_W-1:0] if_id_instr_out,
  output logic [PC_W-1:0]    if_id_pc_plus2_out,
  output logic               if_id_valid_out,
  output logic               halted_out
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_plus2;
  logic [INSTR_W-1:0] buf_data;
  logic               buf_valid;
  logic               captured;
  logic               avail;
  logic [INSTR_W-1:0] load_instr;
  logic               halt_hit;
  logic               buf_load;
  logic               buf_clear;

  assign captured   = imem_req_out & imem_ready_in;
  assign avail      = captured | buf_valid;
  assign load_instr = buf_valid ? buf_data : imem_data_in;
  assign halt_hit   = (load_instr[INSTR_W-1 -: 5] == HALT_OPC);
  assign pc_plus2   = pc_q + PC_W'(2);

  // A redirect or a successful IF/ID load empties the buffer; only a stalled capture fills it.
  assign buf_clear  = redirect_valid_in | (if_id_write_en_in & avail);
  assign buf_load   = ~redirect_valid_in & ~if_id_write_en_in & captured;

  fetch_skid_buffer #(.DATA_W(INSTR_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (imem_data_in),
    .dout  (buf_data),
    .valid (buf_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid_in) begin
      state_d = ST_FETCH;
    end else if (if_id_write_en_in) begin
      if (avail) state_d = halt_hit ? ST_HALTED : ST_FETCH;
    end else if (captured) begin
      state_d = ST_HOLD;
    end
  end

  always_comb begin
    imem_req_out = rst_n & (state_q == ST_FETCH);
    halted_out   = (state_q == ST_HALTED);
  end

  assign imem_addr_out = pc_q;

  // Bubbles and stalls leave pc_plus2 untouched; only reset and real loads write it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q               <= RESET_PC;
      if_id_instr_out    <= NOP_INSTR;
      if_id_pc_plus2_out <= '0;
      if_id_valid_out    <= 1'b0;
    end else if (redirect_valid_in) begin
      pc_q            <= redirect_pc_in;
      if_id_instr_out <= NOP_INSTR;
      if_id_valid_out <= 1'b0;
    end else if (if_id_write_en_in) begin
      if (avail) begin
        if_id_instr_out    <= load_instr;
        if_id_pc_plus2_out <= pc_plus2;
        if_id_valid_out    <= 1'b1;
        if (pc_write_en_in) pc_q <= pc_plus2;
      end else begin
        if_id_instr_out <= NOP_INSTR;
        if_id_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: cycle-level model plus hand-computed spot checks.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_we = 1'b1, ifid_we = 1'b1, redir_v = 1'b0, ready = 1'b0;
  logic [15:0] redir_pc = '0;
  logic        req, valid, halted;
  logic [15:0] imem_addr, imem_data, instr, pc2;
  logic [15:0] halt_addr = 16'hFFFF;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic        chk_en = 1'b0;

  // Model state: what IF/ID and the fetch unit must look like this cycle.
  logic [15:0] m_pc = '0, m_instr = '0, m_pc2 = '0;
  logic        m_valid = 1'b0, m_halted = 1'b0, m_req = 1'b0;
  logic [15:0] skid_q[$];

  always #5 clk = ~clk;

  // Memory image: opcode 10101 plus address bits, with one HALT word planted at halt_addr.
  function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
    if (a == h) return 16'h0000;
    return {5'b10101, a[11:1]};
  endfunction

  assign imem_data = mem_word(imem_addr, halt_addr);

  if_id_fetch_stage #(
    .PC_W      (16),
    .INSTR_W   (16),
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800),
    .HALT_OPC  (5'b00000)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_write_en_in     (pc_we),
    .if_id_write_en_in  (ifid_we),
    .redirect_valid_in  (redir_v),
    .redirect_pc_in     (redir_pc),
    .imem_req_out       (req),
    .imem_addr_out      (imem_addr),
    .imem_ready_in      (ready),
    .imem_data_in       (imem_data),
    .if_id_instr_out    (instr),
    .if_id_pc_plus2_out (pc2),
    .if_id_valid_out    (valid),
    .halted_out         (halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req",      {15'd0, req},    {15'd0, m_req});
      chk("addr",     imem_addr,       m_pc);
      chk("instr",    instr,           m_instr);
      chk("pc_plus2", pc2,             m_pc2);
      chk("valid",    {15'd0, valid},  {15'd0, m_valid});
      chk("halted",   {15'd0, halted}, {15'd0, m_halted});
    end
  end

  task automatic step(input logic rn, input logic wpc, input logic wif, input logic rv,
                      input logic [15:0] rpc, input logic rdy);
    logic        got, have, full;
    logic [15:0] word;
    logic [15:0] n_pc, n_instr, n_pc2;
    logic        n_valid, n_halted;
    rst_n = rn; pc_we = wpc; ifid_we = wif; redir_v = rv; redir_pc = rpc; ready = rdy;
    full  = (skid_q.size() != 0);
    m_req = rn && !m_halted && !full;
    got   = m_req && rdy;
    have  = got || full;
    word  = full ? skid_q[0] : mem_word(m_pc, halt_addr);
    n_pc = m_pc; n_instr = m_instr; n_pc2 = m_pc2; n_valid = m_valid; n_halted = m_halted;
    if (!rn) begin
      n_pc = 16'h0000; n_instr = 16'h0800; n_pc2 = 16'h0000; n_valid = 1'b0; n_halted = 1'b0;
      skid_q.delete();
    end else if (rv) begin
      n_pc = rpc; n_instr = 16'h0800; n_valid = 1'b0; n_halted = 1'b0;
      skid_q.delete();
    end else if (wif && have) begin
      n_instr = word; n_valid = 1'b1; n_pc2 = m_pc + 16'd2;
      if (wpc) n_pc = m_pc + 16'd2;
      n_halted = (word[15:11] == 5'b00000);
      skid_q.delete();
    end else if (wif) begin
      n_instr = 16'h0800; n_valid = 1'b0;
    end else if (got) begin
      skid_q.push_back(mem_word(m_pc, halt_addr));
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc2 = n_pc2; m_valid = n_valid; m_halted = n_halted;
    chk_en = 1'b1;
  endtask

  // Shorthands: normal run, stall, redirect, reset.
  task automatic run(input logic rdy);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, rdy);
  endtask
  task automatic stall(input logic rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, rdy);
  endtask
  task automatic redirect(input logic [15:0] tgt, input logic rdy);
    step(1'b1, 1'b0, 1'b0, 1'b1, tgt, rdy);
  endtask

  initial begin
    // 1: reset, then free-running fetch
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_rst_req",   {15'd0, req}, 16'd0);
    chk("lit_rst_instr", instr, 16'h0800);
    chk("lit_rst_pc2",   pc2, 16'h0000);
    chk("lit_rst_addr",  imem_addr, 16'h0000);
    run(1'b1);
    chk("lit_c1_instr", instr, 16'hA800);
    chk("lit_c1_pc2",   pc2, 16'h0002);
    run(1'b1);
    chk("lit_c2_pc2",  pc2, 16'h0004);
    chk("lit_c2_addr", imem_addr, 16'h0004);

    // 2: stall two cycles while 0004 returns; release drains the buffer
    stall(1'b1);
    chk("lit_hold_req",   {15'd0, req}, 16'd0);
    chk("lit_hold_instr", instr, 16'hA801);
    stall(1'b1);
    run(1'b0);
    chk("lit_rel_instr", instr, 16'hA802);
    chk("lit_rel_pc2",   pc2, 16'h0006);
    chk("lit_rel_addr",  imem_addr, 16'h0006);

    // 3: three memory-wait bubbles, then PC-held load repeats the same word
    for (int i = 0; i < 3; i++) run(1'b0);
    chk("lit_wait_valid", {15'd0, valid}, 16'd0);
    chk("lit_wait_req",   {15'd0, req}, 16'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
    run(1'b1);
    chk("lit_rep_instr", instr, 16'hA803);
    chk("lit_rep_addr",  imem_addr, 16'h0008);

    // 4: buffer full, then redirect while stalled
    stall(1'b1);
    redirect(16'h0040, 1'b1);
    chk("lit_redir_addr", imem_addr, 16'h0040);
    chk("lit_redir_req",  {15'd0, req}, 16'd1);
    run(1'b0);
    chk("lit_redir_bufclr", {15'd0, valid}, 16'd0);
    run(1'b1);
    chk("lit_redir_instr", instr, 16'hA820);

    // 5: HALT fetch, frozen, redirect exit; then redirect beats a HALT capture
    halt_addr = 16'h0042;
    run(1'b1);
    chk("lit_halt",       {15'd0, halted}, 16'd1);
    chk("lit_halt_instr", instr, 16'h0000);
    run(1'b1);
    run(1'b1);
    chk("lit_halt_req",  {15'd0, req}, 16'd0);
    chk("lit_halt_addr", imem_addr, 16'h0044);
    redirect(16'h0010, 1'b0);
    chk("lit_unhalt", {15'd0, halted}, 16'd0);
    run(1'b1);
    chk("lit_unhalt_instr", instr, 16'hA808);
    halt_addr = 16'h0012;
    redirect(16'h0100, 1'b1);
    chk("lit_halt_squash", {15'd0, halted}, 16'd0);
    halt_addr = 16'hFFFF;

    // 6: PC wrap, then reset in the middle of a memory wait
    redirect(16'hFFFE, 1'b0);
    run(1'b1);
    chk("lit_wrap_pc2",  pc2, 16'h0000);
    chk("lit_wrap_addr", imem_addr, 16'h0000);
    chk("lit_wrap_instr", instr, 16'hAFFF);
    run(1'b1);
    run(1'b1);
    run(1'b0);
    stall(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_rst2_addr", imem_addr, 16'h0000);
    chk("lit_rst2_pc2",  pc2, 16'h0000);
    run(1'b0);
    chk("lit_rst2_late", {15'd0, valid}, 16'd0);
    run(1'b1);
    run(1'b1);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
